// File: rtl/sdram_ctrl.sv
// sdram_ctrl: single-port SDR SDRAM controller (init, auto-refresh, BL=1 read/write with auto-precharge)
// Ports: clk/rst (async, active-high); req_valid/req_ready/req_we/req_addr{ba,row,col}/req_wdata/req_wmask
//   core request; resp_valid/resp_rdata read response; init_done sticky init flag; cke/cs/cmd{ras_n,cas_n,we_n}/
//   dqm/ba/addr/write_data/wr_en/read_data SDRAM pins.
// Optional: SDRAM_PERF_CNT_EN adds ref_cnt (post-init REF commands) and acc_cnt (accepted requests).
module sdram_ctrl #(
  parameter int CLK_MHZ   = 50,
  parameter int T_INIT_US = 200,
  parameter int T_RP_CYC  = 2,
  parameter int T_RCD_CYC = 2,
  parameter int T_RFC_CYC = 4,
  parameter int T_MRD_CYC = 2,
  parameter int T_WR_CYC  = 2,
  parameter int CAS_LAT   = 2,
  parameter int REFI_CYC  = 390
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_wmask,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        init_done,
  output logic        cke,
  output logic        cs,
  output logic [2:0]  cmd,
  output logic [1:0]  dqm,
  output logic [1:0]  ba,
  output logic [12:0] addr,
  output logic [15:0] write_data,
  output logic        wr_en,
  input  logic [15:0] read_data
`ifdef SDRAM_PERF_CNT_EN
  ,
  output logic [31:0] ref_cnt,
  output logic [31:0] acc_cnt
`endif
);
  localparam int INIT_CYC = T_INIT_US * CLK_MHZ;
  localparam int RD_REC = ((CAS_LAT + 1 > T_RP_CYC) ? CAS_LAT + 1 : T_RP_CYC) - 1;
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;
  localparam logic [12:0] MODE = {6'b0, 3'(CAS_LAT), 4'b0};
  typedef enum logic [3:0] {
    INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, RFSH, ACT_WAIT, RECOVER
  } state_t;
  state_t state;
  logic [15:0] cnt, refi_cnt, wdata_q;
  logic [8:0] col_q;
  logic [1:0] wmask_q;
  logic [3:0] rd_sh;
  logic ref_pend, we_q, wrap, rdy_nxt;
  assign wrap = init_done && refi_cnt == 16'(REFI_CYC - 1);
  // ready is withheld one cycle ahead of the wrap so a request arriving on the wrap edge loses to refresh
  assign rdy_nxt = !(ref_pend || wrap || (init_done && refi_cnt == 16'(REFI_CYC - 2)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT_WAIT;
      cnt <= 16'(INIT_CYC);
      refi_cnt <= '0;
      ref_pend <= 1'b0;
      cke <= 1'b0;
      cs <= 1'b1;
      cmd <= C_NOP;
      dqm <= 2'b11;
      ba <= '0;
      addr <= '0;
      wr_en <= 1'b0;
      write_data <= '0;
      req_ready <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      init_done <= 1'b0;
      rd_sh <= '0;
      we_q <= 1'b0;
      col_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      cke <= 1'b1;
      cs <= 1'b0;
      cmd <= C_NOP;
      dqm <= 2'b11;
      wr_en <= 1'b0;
      req_ready <= 1'b0;
      resp_valid <= 1'b0;
      rd_sh <= {rd_sh[2:0], 1'b0};
      if (init_done) refi_cnt <= wrap ? '0 : refi_cnt + 16'd1;
      // rd_sh bit k marks the cycle k after RD; read_data is valid in cycle RD+CAS_LAT
      if (rd_sh[2'(CAS_LAT)]) begin
        resp_valid <= 1'b1;
        resp_rdata <= read_data;
      end
      if (cnt != '0) cnt <= cnt - 16'd1;
      else case (state)
        INIT_WAIT: begin
          cmd <= C_PRE;
          addr <= 13'h0400;
          cnt <= 16'(T_RP_CYC);
          state <= INIT_PRE;
        end
        INIT_PRE: begin
          cmd <= C_REF;
          cnt <= 16'(T_RFC_CYC);
          state <= INIT_REF1;
        end
        INIT_REF1: begin
          cmd <= C_REF;
          cnt <= 16'(T_RFC_CYC);
          state <= INIT_REF2;
        end
        INIT_REF2: begin
          cmd <= C_MRS;
          ba <= '0;
          addr <= MODE;
          cnt <= 16'(T_MRD_CYC);
          state <= INIT_MRS;
        end
        INIT_MRS: begin
          init_done <= 1'b1;
          req_ready <= 1'b1;
          state <= IDLE;
        end
        IDLE: begin
          if (ref_pend) begin
            cmd <= C_REF;
            ref_pend <= 1'b0;
            cnt <= 16'(T_RFC_CYC);
            state <= RFSH;
          end else if (req_valid && req_ready) begin
            we_q <= req_we;
            col_q <= req_addr[8:0];
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            cmd <= C_ACT;
            ba <= req_addr[23:22];
            addr <= req_addr[21:9];
            cnt <= 16'(T_RCD_CYC - 1);
            state <= ACT_WAIT;
          end else req_ready <= rdy_nxt;
        end
        ACT_WAIT: begin
          cmd <= we_q ? C_WR : C_RD;
          addr <= {4'b0010, col_q};
          write_data <= we_q ? wdata_q : write_data;
          wr_en <= we_q;
          dqm <= we_q ? ~wmask_q : 2'b00;
          rd_sh[0] <= !we_q;
          cnt <= we_q ? 16'(T_WR_CYC + T_RP_CYC) : 16'(RD_REC);
          state <= RECOVER;
        end
        default: begin
          req_ready <= rdy_nxt;
          state <= IDLE;
        end
      endcase
      if (wrap) ref_pend <= 1'b1;
    end
  end
`ifdef SDRAM_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      acc_cnt <= '0;
    end else begin
      if (state == IDLE && ref_pend) ref_cnt <= ref_cnt + 32'd1;
      if (state == IDLE && !ref_pend && req_valid && req_ready) acc_cnt <= acc_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sdram_ctrl.sv
// tb_sdram_ctrl: scoreboard bench for sdram_ctrl with an SDRAM device model and a request-level memory model
module tb_sdram_ctrl;
  localparam int CLK_MHZ = 50, T_INIT_US = 200, T_RP = 2, T_RCD = 2, T_RFC = 4, T_MRD = 2, T_WR = 2;
  localparam int CL = 2, REFI = 390;
  localparam int INIT_CYC = T_INIT_US * CLK_MHZ;
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_MRS = 3'b000;
  typedef struct {
    logic we;
    logic [23:0] a;
    logic [15:0] d;
    logic [1:0] m;
  } req_t;
  logic clk = 0, rst = 0;
  logic req_valid = 0, req_we = 0;
  logic [23:0] req_addr = 0;
  logic [15:0] req_wdata = 0;
  logic [1:0] req_wmask = 0;
  logic req_ready, resp_valid, init_done, cke, cs, wr_en;
  logic [15:0] resp_rdata, write_data, read_data;
  logic [2:0] cmd;
  logic [1:0] dqm, ba;
  logic [12:0] addr;
`ifdef SDRAM_PERF_CNT_EN
  logic [31:0] ref_cnt, acc_cnt;
`endif
  int vec = 0, errs = 0, cyc = 0;
  int d_cyc = 0, n_ref = 0, ref_cyc = 0, act_cyc = 0, rd_cyc = 0, n_acc = 0;
  bit seen_done = 0;
  req_t acc_q[$];
  logic [15:0] exp_q[$];
  req_t cur;
  bit [15:0] ref_mem[int];
  bit [15:0] dev_mem[int];
  logic [12:0] open_row[4];
  int pend_cnt = -1;
  logic [15:0] pend_word = 0;
  logic [23:0] pool[8];

  sdram_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .init_done(init_done), .cke(cke), .cs(cs), .cmd(cmd), .dqm(dqm),
    .ba(ba), .addr(addr), .write_data(write_data), .wr_en(wr_en), .read_data(read_data)
`ifdef SDRAM_PERF_CNT_EN
    , .ref_cnt(ref_cnt), .acc_cnt(acc_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] m);
    return {m[1] ? d[15:8] : old[15:8], m[0] ? d[7:0] : old[7:0]};
  endfunction

  function automatic logic [15:0] ref_rd(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : 16'h0;
  endfunction

  function automatic logic [15:0] dev_rd(input int k);
    return dev_mem.exists(k) ? dev_mem[k] : 16'h0;
  endfunction

  // SDRAM device: latches the open row on ACT, applies masked writes, returns read data CL edges after RD
  always @(posedge clk) begin
    int k;
    if (cs === 1'b0 && cmd == C_ACT) open_row[ba] = addr;
    if (cs === 1'b0 && cmd == C_WR && wr_en) begin
      k = int'({ba, open_row[ba], addr[8:0]});
      dev_mem[k] = merge(dev_rd(k), write_data, ~dqm);
    end
    if (cs === 1'b0 && cmd == C_RD) begin
      pend_cnt = CL - 1;
      pend_word = dev_rd(int'({ba, open_row[ba], addr[8:0]}));
    end else if (pend_cnt >= 0) pend_cnt--;
    read_data <= (pend_cnt == 0) ? pend_word : 16'($urandom);
  end

  // monitor: checks every pin-level command and response against the accepted-request scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (init_done && !seen_done) begin
        seen_done = 1;
        d_cyc = cyc;
        n_ref = 0;
      end
      if (!cs && cmd == C_REF && init_done) begin
        n_ref++;
        ref_cyc = cyc;
        check("ref_interval", 64'(cyc > d_cyc + n_ref * REFI && cyc <= d_cyc + n_ref * REFI + 12), 64'd1);
      end
      if (!cs && cmd == C_ACT) begin
        if (acc_q.size() == 0) check("act_unexpected", 64'(cmd), 64'(C_NOP));
        else begin
          cur = acc_q.pop_front();
          check("act_ba_row", 64'({ba, addr}), 64'(cur.a[23:9]));
        end
        act_cyc = cyc;
      end
      if (!cs && (cmd == C_RD || cmd == C_WR)) begin
        check("rw_cmd", 64'(cmd), 64'(cur.we ? C_WR : C_RD));
        check("rcd_delay", 64'(cyc - act_cyc), 64'(T_RCD));
        check("rw_addr", 64'({ba, addr}), 64'({cur.a[23:22], 4'b0010, cur.a[8:0]}));
        if (cmd == C_WR) check("wr_pins", 64'({wr_en, dqm, write_data}), 64'({1'b1, ~cur.m, cur.d}));
        else check("rd_pins", 64'({wr_en, dqm}), 64'(3'b000));
        rd_cyc = cyc;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) check("resp_unexpected", 64'(resp_valid), 64'd0);
        else begin
          check("rdata", 64'(resp_rdata), 64'(exp_q.pop_front()));
          check("cas_delay", 64'(cyc - rd_cyc), 64'(CL + 1));
        end
      end
    end
  end

  task automatic check_reset_outs();
    check("reset_outs",
          64'({cke, cs, cmd, dqm, ba, addr, wr_en, write_data, req_ready, resp_valid, resp_rdata, init_done}),
          64'({1'b0, 1'b1, 3'b111, 2'b11, 2'b00, 13'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0}));
`ifdef SDRAM_PERF_CNT_EN
    check("reset_cnts", {ref_cnt, acc_cnt}, 64'd0);
`endif
  endtask

  task automatic step(input string name, input logic [2:0] c);
    @(negedge clk);
    check(name, 64'({cke, cs, cmd, init_done, req_ready}), 64'({1'b1, 1'b0, c, 1'b0, 1'b0}));
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step("init_nop", C_NOP);
  endtask

  task automatic init_check();
    nops(INIT_CYC);
    step("init_pre", C_PRE);
    check("init_pre_a10", 64'(addr[10]), 64'd1);
    nops(T_RP);
    step("init_ref1", C_REF);
    nops(T_RFC);
    step("init_ref2", C_REF);
    nops(T_RFC);
    step("init_mrs", C_MRS);
    check("init_mrs_addr", 64'({ba, addr}), 64'({2'b00, 13'h020}));
    nops(T_MRD);
    @(negedge clk);
    check("init_done", 64'({init_done, req_ready, cmd}), 64'({1'b1, 1'b1, C_NOP}));
  endtask

  task automatic do_req(input logic we, input logic [23:0] a, input logic [15:0] d, input logic [1:0] m);
    int n = 0;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
    while (!req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 0;
      return;
    end
    acc_q.push_back('{we, a, d, m});
    n_acc++;
    if (we) ref_mem[int'(a)] = merge(ref_rd(int'(a)), d, m);
    else exp_q.push_back(ref_rd(int'(a)));
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size() + acc_q.size()), 64'd0);
  endtask

  initial begin
    int w, n;
    logic [23:0] a0;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    check_reset_outs();
    rst = 0;
    init_check();

    a0 = {2'd0, 13'h052, 9'd3};
    do_req(1, a0, 16'hBEEF, 2'b11);
    do_req(0, a0, 16'h0, 2'b00);
    do_req(1, a0, 16'h1234, 2'b01);
    do_req(0, a0, 16'h0, 2'b00);
    drain();

    // refresh collision: request first appears on the cycle the refresh counter wraps
    w = d_cyc + REFI;
    while (w < cyc + 5) w += REFI;
    while (cyc < w - 1) @(negedge clk);
    check("pre_wrap_ready", 64'(req_ready), 64'd0);
    do_req(1, 24'h3ABCDE, 16'hC0DE, 2'b11);
    check("coll_ref_cyc", 64'(ref_cyc), 64'(w + 1));
    check("coll_act_cyc", 64'(cyc), 64'(w + 1 + T_RFC + 2));
    drain();
    do_req(0, 24'h3ABCDE, 16'h0, 2'b00);

    for (int i = 0; i < 8; i++) pool[i] = 24'($urandom);
    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 16'($urandom), 2'($urandom));
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    drain();
    repeat (3 * REFI + 20) @(negedge clk);
`ifdef SDRAM_PERF_CNT_EN
    if (!cs && cmd == C_REF) @(negedge clk);
    check("acc_cnt", 64'(acc_cnt), 64'(n_acc));
    check("ref_cnt", 64'(ref_cnt), 64'(n_ref));
`endif

    // reset while a read is in flight
    do_req(0, a0, 16'h0, 2'b00);
    n = 0;
    while (!(cs == 1'b0 && cmd == C_RD) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midread_rd_seen", 64'(cmd), 64'(C_RD));
    rst = 1;
    #1;
    check_reset_outs();
    exp_q.delete();
    acc_q.delete();
    seen_done = 0;
    n_acc = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    init_check();
    do_req(1, a0, 16'h5A5A, 2'b10);
    do_req(0, a0, 16'h0, 2'b00);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
